// File: rtl/addr_arb_pkg.sv
// Shared types and default constants for the address request arbiter.
//   ADDR_ARB_NUM_REQ / ADDR_ARB_ADDR_W : default requester count and address width
//   addr_req_t                         : address-path payload at the default width
//   slot_state_e                       : occupancy of the single output register
package addr_arb_pkg;

  localparam int unsigned ADDR_ARB_NUM_REQ = 4;
  localparam int unsigned ADDR_ARB_ADDR_W  = 8;

  typedef struct packed {
    logic [ADDR_ARB_ADDR_W-1:0] address;
    logic                       address_valid;
  } addr_req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : search start index (always < NUM_REQ)
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : winner index
//   any   : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Linear scan of the rotated order; first hit wins.
  always_comb begin
    int unsigned j;
    j     = 0;
    any   = 1'b0;
    idx   = '0;
    grant = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[ID_W'(j)]) begin
        any = 1'b1;
        idx = ID_W'(j);
      end
    end
    if (any) grant = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/addr_req_arbiter.sv
// Round-robin arbiter feeding a single valid/ready address register stage.
//   CLK, RESET        : clock, synchronous active-high reset
//   req_valid/req_address/req_address_valid : per-requester payload
//   req_ready         : one-hot accept strobe (combinational)
//   out_valid/out_address/out_address_valid/out_id : held payload
//   out_ready         : downstream accept
// Optional build macro ADDR_ARB_STATS_EN adds stall_count and grant_count.
module addr_req_arbiter
  import addr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = ADDR_ARB_NUM_REQ,
  parameter int unsigned ADDR_W  = ADDR_ARB_ADDR_W,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ-1:0]              req_address_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [ADDR_W-1:0]               out_address,
  output logic                            out_address_valid,
  output logic [ID_W-1:0]                 out_id,
  input  logic                            out_ready
`ifdef ADDR_ARB_STATS_EN
  ,
  output logic [31:0]                     stall_count,
  output logic [NUM_REQ-1:0][15:0]        grant_count
`endif
);

  slot_state_e          state_q, state_d;
  logic [ID_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 slot_free_c;
  logic                 load_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign out_valid = (state_q == FULL);

  // Next state, load strobe and accept strobe; reset suppresses any grant.
  always_comb begin
    state_d     = state_q;
    load_c      = 1'b0;
    req_ready   = '0;
    slot_free_c = (state_q == EMPTY) || out_ready;
    if (!RESET && slot_free_c && pick_any) begin
      load_c    = 1'b1;
      req_ready = pick_grant;
    end
    case (state_q)
      EMPTY:   if (load_c) state_d = FULL;
      FULL:    if (out_ready && !load_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State, output register and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q           <= EMPTY;
      out_address       <= '0;
      out_address_valid <= 1'b0;
      out_id            <= '0;
      rr_ptr            <= '0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        out_address       <= req_address[pick_idx];
        out_address_valid <= req_address_valid[pick_idx];
        out_id            <= pick_idx;
        rr_ptr            <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
    end
  end

`ifdef ADDR_ARB_STATS_EN
  // Saturating stall counter and wrapping per-requester grant counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_count <= '0;
      grant_count <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
      if (load_c)
        grant_count[pick_idx] <= grant_count[pick_idx] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_addr_req_arbiter.sv
module tb_addr_req_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned AW = 8;

  logic              CLK;
  logic              RESET;
  logic [N-1:0]      req_valid;
  logic [N-1:0][AW-1:0] req_address;
  logic [N-1:0]      req_address_valid;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [AW-1:0]     out_address;
  logic              out_address_valid;
  logic [1:0]        out_id;
  logic              out_ready;
`ifdef ADDR_ARB_STATS_EN
  logic [31:0]       stall_count;
  logic [N-1:0][15:0] grant_count;
`endif

  addr_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .req_valid         (req_valid),
    .req_address       (req_address),
    .req_address_valid (req_address_valid),
    .req_ready         (req_ready),
    .out_valid         (out_valid),
    .out_address       (out_address),
    .out_address_valid (out_address_valid),
    .out_id            (out_id),
    .out_ready         (out_ready)
`ifdef ADDR_ARB_STATS_EN
    ,
    .stall_count       (stall_count),
    .grant_count       (grant_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one held slot plus a rotating search start.
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic          m_av;
  int            m_id;
  int            m_ptr;
  longint        m_stall;
  int            m_gc [N];

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (RESET) return r;
    if (m_valid && !out_ready) return r;
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (m_ptr + k) % int'(N);
      if (req_valid[j]) begin
        r[j] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] model_out();
    return {m_valid, m_av, 2'(m_id), m_addr};
  endfunction

  function automatic logic [11:0] dut_out();
    return {out_valid, out_address_valid, out_id, out_address};
  endfunction

  // One clock: update the model with the inputs seen at the edge, return at the falling edge.
  task automatic tick();
    logic [N-1:0] r;
    int w;
    r = model_ready();
    w = -1;
    for (int i = 0; i < int'(N); i++) if (r[i]) w = i;
    @(posedge CLK);
    if (RESET) begin
      m_valid = 1'b0; m_addr = '0; m_av = 1'b0; m_id = 0; m_ptr = 0; m_stall = 0;
      for (int i = 0; i < int'(N); i++) m_gc[i] = 0;
    end else begin
      if (m_valid && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (w >= 0) begin
        m_valid = 1'b1;
        m_addr  = req_address[w];
        m_av    = req_address_valid[w];
        m_id    = w;
        m_ptr   = (w + 1) % int'(N);
        m_gc[w] = (m_gc[w] + 1) % 65536;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < int'(N); i++) begin
      req_address[i]       = AW'($urandom);
      req_address_valid[i] = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    randomize_payload();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (req_ready !== 4'b0000)
        $display("FAIL reset_ready cycle %0d: got %b expected 0000", c, req_ready);
      else n_pass++;
      tick();
    end
    RESET = 1'b0;
    req_valid = '0;
    #1;
    n_checks++;
    if (dut_out() !== 12'h000 || req_ready !== 4'b0000)
      $display("FAIL reset_state: got out=%h ready=%b expected out=000 ready=0000", dut_out(), req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (dut_out() !== 12'h000)
      $display("FAIL reset_idle: got %h expected 000", dut_out());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      randomize_payload();
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << (c % 4)) || req_ready !== model_ready())
        $display("FAIL rr_ready cycle %0d: got %b expected %b", c, req_ready, 4'b0001 << (c % 4));
      else n_pass++;
      tick();
      n_checks++;
      if (out_id !== 2'(c % 4) || out_valid !== 1'b1 || dut_out() !== model_out())
        $display("FAIL rr_out cycle %0d: got %h expected %h", c, dut_out(), model_out());
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    req_valid = 4'b0100;
    req_address[2] = 8'hA5;
    req_address_valid[2] = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_address !== 8'hA5 || out_id !== 2'd2 || out_address_valid !== 1'b1)
      $display("FAIL hold_load: got %h expected %h", dut_out(), model_out());
    else n_pass++;
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      randomize_payload();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000)
        $display("FAIL hold_ready cycle %0d: got %b expected 0000", c, req_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_address !== 8'hA5 || out_id !== 2'd2 || out_valid !== 1'b1)
        $display("FAIL hold_stable cycle %0d: got %h expected %h", c, dut_out(), model_out());
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000)
      $display("FAIL hold_release_ready: got %b expected 1000", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd3 || dut_out() !== model_out())
      $display("FAIL hold_release_out: got %h expected %h", dut_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_ptr_wrap();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010)
      $display("FAIL wrap_ready1: got %b expected 0010", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd1 || dut_out() !== model_out())
      $display("FAIL wrap_out1: got %h expected %h", dut_out(), model_out());
    else n_pass++;
    req_valid = 4'b1001;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000)
      $display("FAIL wrap_ready2: got %b expected 1000", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_id !== 2'd3 || dut_out() !== model_out())
      $display("FAIL wrap_out2: got %h expected %h", dut_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'($urandom_range(1, 15));
      randomize_payload();
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || dut_out() !== model_out())
        $display("FAIL b2b_out cycle %0d: got %h expected %h", c, dut_out(), model_out());
      else n_pass++;
    end
    RESET = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000)
      $display("FAIL midreset_ready: got %b expected 0000", req_ready);
    else n_pass++;
    tick();
    RESET = 1'b0;
    req_valid = '0;
    n_checks++;
    if (out_valid !== 1'b0 || dut_out() !== 12'h000)
      $display("FAIL midreset_out: got %h expected 000", dut_out());
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 39) == 0);
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      randomize_payload();
      #1;
      n_checks++;
      if (req_ready !== model_ready())
        $display("FAIL rand_ready cycle %0d: got %b expected %b", c, req_ready, model_ready());
      else n_pass++;
      tick();
      n_checks++;
      if (dut_out() !== model_out())
        $display("FAIL rand_out cycle %0d: got %h expected %h", c, dut_out(), model_out());
      else n_pass++;
    end
    RESET = 1'b0;
  endtask

`ifdef ADDR_ARB_STATS_EN
  task automatic test_stats();
    RESET = 1'b1;
    req_valid = '0;
    tick();
    RESET = 1'b0;
    out_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    for (int c = 0; c < 7; c++) tick();
    n_checks++;
    if (stall_count !== 32'd7 || longint'(stall_count) != m_stall)
      $display("FAIL stats_stall: got %0d expected 7", stall_count);
    else n_pass++;
    out_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (grant_count[1] !== 16'd3 || int'(grant_count[1]) != m_gc[1])
      $display("FAIL stats_grant: got %0d expected 3", grant_count[1]);
    else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1;
    req_valid = '0;
    req_address = '0;
    req_address_valid = '0;
    out_ready = 1'b0;
    m_valid = 1'b0; m_addr = '0; m_av = 1'b0; m_id = 0; m_ptr = 0; m_stall = 0;
    for (int i = 0; i < int'(N); i++) m_gc[i] = 0;
    @(negedge CLK);
    test_reset();
    test_round_robin();
    test_hold();
    test_ptr_wrap();
    test_back_to_back();
    test_random();
`ifdef ADDR_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_req_arbiter.md
# addr_req_arbiter

Round-robin arbiter that shares one address pipeline register stage among `NUM_REQ` requesters. Each requester offers an `{address, addressValid, valid}` payload. The block grants one requester per cycle, captures the winner into a single output register with a valid/ready handshake, and holds it until the downstream consumer accepts it. It sits in front of the address-path register stage and is the only writer of that stage.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2–16.
- `ADDR_W`, default 8: address width.
- `ID_W`, default `$clog2(NUM_REQ)`: grant index width.

Ports:
- `CLK`  in  1  clock; all logic is on the rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester payload valid.
- `req_address`  in  `NUM_REQ`×`ADDR_W`  per-requester address.
- `req_address_valid`  in  `NUM_REQ`  per-requester addressValid flag.
- `req_ready`  out  `NUM_REQ`  one-hot accept strobe; a transfer happens when `req_valid[i]` and `req_ready[i]` are both high.
- `out_valid`  out  1  output register holds a payload.
- `out_address`  out  `ADDR_W`  registered address.
- `out_address_valid`  out  1  registered addressValid.
- `out_id`  out  `ID_W`  index of the requester whose payload is held.
- `out_ready`  in  1  downstream accept.

## Operation
- Output register state machine: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `slot_free` = EMPTY, or (FULL and `out_ready`).
- Arbitration runs only when `slot_free` is high. The winner is the first `i` with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
- `req_ready[winner]` = 1. All other bits of `req_ready` are 0. If `slot_free` is 0, `req_ready` is all zero.
- On a grant, the output register loads `{req_address[w], req_address_valid[w], w}` and `rr_ptr` becomes `(w+1) mod NUM_REQ`. The wrap from `NUM_REQ-1` goes to 0.
- State transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `out_ready` with no grant.
  - FULL→FULL on `out_ready` with a grant in the same cycle (back-to-back, no bubble).
  - FULL→FULL with no load while `out_ready` is low.
- `out_*` signals stay stable while `out_valid`=1 and `out_ready`=0.
- A requester's `req_valid` does not need to be sticky. Dropping it before it is granted is legal.
- `rr_ptr` holds when there is no grant.
- Reset values:
  - `out_valid`=0, `out_address`=0, `out_address_valid`=0, `out_id`=0.
  - `rr_ptr`=0, state EMPTY.
  - `req_ready` is all zero during the reset cycle.
- Reset applied mid-transfer discards the held payload. No `req_ready` is asserted in a cycle where `RESET`=1.

## Timing
- Latency is 1 cycle from request accept to `out_valid`.
- Throughput is 1 payload per cycle while `out_ready` is held high.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `out_ready`. There is no combinational path from `req_address` to any output.
- Fairness: a continuously asserting requester is granted within `NUM_REQ` grants.

## Configuration
- `ADDR_ARB_STATS_EN` defined:
  - Adds output `stall_count` (32 bits): increments each cycle with `out_valid`=1 and `out_ready`=0, saturates at `2^32-1`, clears on `RESET`.
  - Adds output `grant_count` (`NUM_REQ`×16 bits): per-requester grant counters that wrap modulo `2^16` and clear on `RESET`.
- `ADDR_ARB_STATS_EN` undefined: neither port nor the counters exist. Arbitration behaviour is identical in both builds.

## Structure
- Shared package `addr_arb_pkg`:
  - `addr_req_t` struct `{address[ADDR_W-1:0], address_valid}`.
  - Default constants `ADDR_ARB_NUM_REQ`=4 and `ADDR_ARB_ADDR_W`=8.
  - Enum `slot_state_e {EMPTY, FULL}`.
- Sub-module `rr_pick`: combinational rotate-priority encoder. Inputs are the request vector and `rr_ptr`. Outputs are a one-hot grant, the grant index and `any`.
- The top level holds the output register, the state machine, `rr_ptr` and the optional counters.

## Test plan
- Reset, then `req_valid`=0: `out_valid`=0, `req_ready`=0, all `out_*`=0. Hold `RESET` for 3 cycles while `req_valid`=4'b1111: still no `req_ready`.
- All 4 requesters valid continuously, `out_ready`=1: `out_id` sequence is 0,1,2,3,0 on consecutive cycles, with `out_valid` high every cycle after the first.
- Requester 2 sends address 0xA5 with addressValid=1 and `out_ready`=0 for 5 cycles: `out_address`=0xA5 is stable and `req_ready`=0 throughout. Then `out_ready`=1: the next grant loads in the same cycle.
- `rr_ptr`=3, only `req_valid[1]`=1: requester 1 is granted and `rr_ptr` becomes 2. Then `req_valid`=4'b1001: requester 3 is granted.
- FULL with `out_ready`=1 and a new request in the same cycle: no bubble, `out_valid` stays 1 and the payload updates next cycle. Assert `RESET` while FULL: `out_valid`=0 next cycle.
- With `ADDR_ARB_STATS_EN` defined: hold `out_ready`=0 for 7 cycles while FULL → `stall_count`=7. Make 3 grants to requester 1 → `grant_count[1]`=3.
